// File: rtl/csr_rmw_pkg.sv
// csr_rmw_pkg: shared widths, CSR op encoding and response record for csr_rmw_unit
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 32
`endif

package csr_rmw_pkg;
    localparam int UUID_W = `UUID_BITS;
    localparam int NW_W   = `NW_BITS;
    localparam int NT     = `NUM_THREADS;
    localparam int NR_W   = `NR_BITS;
    localparam int AW     = `CSR_ADDR_BITS;
    localparam int PERF_W = `PERF_CTR_BITS;
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;
    typedef enum logic [1:0] {RW = 2'd0, RS = 2'd1, RC = 2'd2} csr_op_t;
    typedef struct packed {
        logic [UUID_W-1:0] uuid;
        logic [NW_W-1:0]   wid;
        logic [NT-1:0]     tmask;
        logic [NR_W-1:0]   rd;
        logic              wb;
        logic [31:0]       data;
    } csr_rsp_t;
endpackage

// File: rtl/csr_rsp_fifo.sv
// csr_rsp_fifo: valid/ready FIFO of csr_rsp_t entries.
// Ports: clk, reset_n (sync active-low), push/push_data (caller guarantees not full),
//        pop_ready (consumer ready), valid/data (head entry), count (occupancy).
module csr_rsp_fifo
    import csr_rmw_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  csr_rsp_t      push_data,
    input  logic          pop_ready,
    output logic          valid,
    output csr_rsp_t      data,
    output logic [CW-1:0] count
);
    csr_rsp_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic pop;
    assign valid = count != '0;
    assign data  = mem[rd_ptr];
    assign pop   = valid & pop_ready;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: execute-stage CSR read-modify-write initiator returning the old CSR value.
// Ports: req_* from dispatch (valid/ready), read_*/write_* to CSR storage (combinational,
//        gated by accept), rsp_* to commit (valid/ready), ro_write_err pulse, busy.
// Optional: define CSR_RMW_PERF_EN to add perf_reads/perf_writes/perf_stalls counters.
module csr_rmw_unit
    import csr_rmw_pkg::*;
#(
    parameter int OUT_BUF_SIZE = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [UUID_W-1:0] req_uuid,
    input  logic [NW_W-1:0]   req_wid,
    input  logic [NT-1:0]     req_tmask,
    input  logic [NR_W-1:0]   req_rd,
    input  logic              req_wb,
    input  csr_op_t           req_op,
    input  logic              req_use_imm,
    input  logic [4:0]        req_imm,
    input  logic [NR_W-1:0]   req_rs1_idx,
    input  logic [31:0]       req_rs1_data,
    input  logic [AW-1:0]     req_addr,
    output logic              read_enable,
    output logic [UUID_W-1:0] read_uuid,
    output logic [AW-1:0]     read_addr,
    output logic [NW_W-1:0]   read_wid,
    input  logic [31:0]       read_data,
    output logic              write_enable,
    output logic [UUID_W-1:0] write_uuid,
    output logic [AW-1:0]     write_addr,
    output logic [NW_W-1:0]   write_wid,
    output logic [31:0]       write_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [UUID_W-1:0] rsp_uuid,
    output logic [NW_W-1:0]   rsp_wid,
    output logic [NT-1:0]     rsp_tmask,
    output logic [NR_W-1:0]   rsp_rd,
    output logic              rsp_wb,
    output logic [31:0]       rsp_data,
    output logic              ro_write_err,
`ifdef CSR_RMW_PERF_EN
    output logic [PERF_W-1:0] perf_reads,
    output logic [PERF_W-1:0] perf_writes,
    output logic [PERF_W-1:0] perf_stalls,
`endif
    output logic              busy
);
    localparam int CW = $clog2(OUT_BUF_SIZE + 1);
    logic [CW-1:0] count;
    logic fire, no_read, src_zero, write_req, ro;
    logic [31:0] src, old_val, new_val;
    csr_rsp_t head;
    assign fire      = req_valid & req_ready;
    assign req_ready = reset_n & (count != CW'(OUT_BUF_SIZE));
    assign busy      = req_valid | (count != '0);
    // CSRRW to x0 must not cause read side effects
    assign no_read   = (req_op == RW) & (req_rd == '0);
    assign src       = req_use_imm ? 32'(req_imm) : req_rs1_data;
    assign src_zero  = req_use_imm ? (req_imm == '0) : (req_rs1_idx == '0);
    assign write_req = (req_op == RW) | ~src_zero;
    assign ro        = req_addr[AW-1 -: 2] == CSR_RO_PREFIX;
    assign old_val   = no_read ? '0 : read_data;
    assign new_val   = req_op == RW ? src : req_op == RS ? (read_data | src) : (read_data & ~src);
    assign read_enable  = fire & ~no_read;
    assign read_uuid    = fire ? req_uuid : '0;
    assign read_addr    = fire ? req_addr : '0;
    assign read_wid     = fire ? req_wid : '0;
    assign write_enable = fire & write_req & ~ro;
    assign write_uuid   = fire ? req_uuid : '0;
    assign write_addr   = fire ? req_addr : '0;
    assign write_wid    = fire ? req_wid : '0;
    assign write_data   = fire ? new_val : '0;
    csr_rsp_fifo #(.DEPTH(OUT_BUF_SIZE)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fire),
        .push_data ('{req_uuid, req_wid, req_tmask, req_rd, req_wb, old_val}),
        .pop_ready (rsp_ready),
        .valid     (rsp_valid),
        .data      (head),
        .count     (count)
    );
    assign rsp_uuid  = head.uuid;
    assign rsp_wid   = head.wid;
    assign rsp_tmask = head.tmask;
    assign rsp_rd    = head.rd;
    assign rsp_wb    = head.wb;
    assign rsp_data  = head.data;
    always_ff @(posedge clk) begin
        if (!reset_n) ro_write_err <= 1'b0;
        else ro_write_err <= fire & write_req & ro;
    end
`ifdef CSR_RMW_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            perf_reads  <= perf_reads + PERF_W'(read_enable);
            perf_writes <= perf_writes + PERF_W'(write_enable);
            perf_stalls <= perf_stalls + PERF_W'(req_valid & ~req_ready);
        end
    end
`endif
endmodule
